// File: rtl/spi_arb.sv
// spi_arb: lets the Z80 port path (A) and the hardware sector loader (B) share one SD-card SPI byte engine.
// Optional build macro SPI_ARB_RR_EN: round-robin tie breaking in IDLE instead of fixed A priority.
module spi_arb #(
    parameter int XFER_CE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cen,
    input  logic       a_tx,
    input  logic       a_rx,
    input  logic [7:0] a_d,
    input  logic       a_cs,
    output logic       a_busy,
    output logic       a_gnt,
    output logic       a_ovf,
    input  logic       b_tx,
    input  logic       b_rx,
    input  logic [7:0] b_d,
    input  logic       b_cs,
    output logic       b_busy,
    output logic       b_gnt,
    output logic       b_ovf,
    output logic       spi_tx,
    output logic       spi_rx,
    output logic [7:0] spi_d,
    output logic       spi_cs
);

    localparam int CW = $clog2(XFER_CE + 1);

    typedef enum logic [1:0] {IDLE, XFER, LOCK} arbState;

    arbState       state, stateNext;
    logic          ownerB, ownerBNext;
    logic [CW-1:0] count;
    logic          aValid, aRx, bValid, bRx;
    logic [7:0]    aByte, bByte;
    logic          aStrobe, bStrobe, reqA, reqB, winnerB;
    logic          ownValid, ownCs, counting, done, start;
    logic          takeA, takeB, selRx;
    logic [7:0]    selByte;
`ifdef SPI_ARB_RR_EN
    logic          lastB;
`endif

    assign aStrobe  = a_tx | a_rx;
    assign bStrobe  = b_tx | b_rx;
    assign reqA     = aValid | ~a_cs;
    assign reqB     = bValid | ~b_cs;
    assign ownValid = ownerB ? bValid : aValid;
    assign ownCs    = ownerB ? b_cs : a_cs;
    // The cycle in which the engine strobe is high does not count toward the byte window.
    assign counting = (state == XFER) && cen && !(spi_tx || spi_rx);
    assign done     = counting && (count == CW'(XFER_CE - 1));

`ifdef SPI_ARB_RR_EN
    assign winnerB = reqB & (~reqA | ~lastB);
`else
    assign winnerB = reqB & ~reqA;
`endif

    always_comb begin
        stateNext  = state;
        ownerBNext = ownerB;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (reqA || reqB) begin
                    ownerBNext = winnerB;
                    start      = winnerB ? bValid : aValid;
                    stateNext  = (winnerB ? bValid : aValid) ? XFER : LOCK;
                end
            end
            XFER: begin
                if (done) begin
                    if (ownValid && !ownCs) begin
                        start     = 1'b1;
                        stateNext = XFER;
                    end else if (!ownCs) begin
                        stateNext = LOCK;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            LOCK: begin
                if (ownValid) begin
                    start     = 1'b1;
                    stateNext = XFER;
                end else if (ownCs) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign takeA   = start & ~ownerBNext;
    assign takeB   = start & ownerBNext;
    assign selRx   = ownerBNext ? bRx : aRx;
    assign selByte = ownerBNext ? bByte : aByte;

    // Bus state, ownership, engine strobes and the per-byte cen counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ownerB <= 1'b0;
            count  <= '0;
            spi_tx <= 1'b0;
            spi_rx <= 1'b0;
            spi_d  <= 8'hFF;
            spi_cs <= 1'b1;
        end else begin
            state  <= stateNext;
            ownerB <= ownerBNext;
            spi_tx <= start & ~selRx;
            spi_rx <= start & selRx;
            spi_cs <= (stateNext == IDLE);
            if (start) begin
                spi_d <= selByte;
            end
            if (start || done) begin
                count <= '0;
            end else if (counting) begin
                count <= count + CW'(1);
            end
        end
    end

`ifdef SPI_ARB_RR_EN
    // Remember who was granted last so the next tie goes the other way.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lastB <= 1'b1;
        end else if (state == IDLE && (reqA || reqB)) begin
            lastB <= winnerB;
        end
    end
`endif

    // Requester A pending slot: a strobe refills it in the same edge the old entry is consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aValid <= 1'b0;
            aRx    <= 1'b0;
            aByte  <= 8'h00;
            a_ovf  <= 1'b0;
        end else begin
            a_ovf <= aStrobe & aValid & ~takeA;
            if (aStrobe && (!aValid || takeA)) begin
                aValid <= 1'b1;
                aRx    <= a_rx;
                aByte  <= a_d;
            end else if (takeA) begin
                aValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bValid <= 1'b0;
            bRx    <= 1'b0;
            bByte  <= 8'h00;
            b_ovf  <= 1'b0;
        end else begin
            b_ovf <= bStrobe & bValid & ~takeB;
            if (bStrobe && (!bValid || takeB)) begin
                bValid <= 1'b1;
                bRx    <= b_rx;
                bByte  <= b_d;
            end else if (takeB) begin
                bValid <= 1'b0;
            end
        end
    end

    assign a_gnt  = (state != IDLE) & ~ownerB;
    assign b_gnt  = (state != IDLE) & ownerB;
    assign a_busy = aValid | ((state == XFER) & ~ownerB);
    assign b_busy = bValid | ((state == XFER) & ownerB);

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: scoreboard bench for spi_arb; each requester has a queue of expected {rx, byte} engine transfers.
// A build with SPI_ARB_RR_EN defined expects B to win the second tie.
module tb_spi_arb;

    logic       clock = 1'b0;
    logic       reset;
    logic       cen;
    logic       a_tx, a_rx, a_cs, b_tx, b_rx, b_cs;
    logic [7:0] a_d, b_d;
    logic       a_busy, a_gnt, a_ovf, b_busy, b_gnt, b_ovf;
    logic       spi_tx, spi_rx, spi_cs;
    logic [7:0] spi_d;

    int         testsRun = 0;
    int         testsFailed = 0;
    int         cenPeriod = 1;
    int         cenCount = 0;
    int         ovfCountA = 0;
    int         ovfCountB = 0;
    int         csHighSamples = 0;
    logic [8:0] aExp[$];
    logic [8:0] bExp[$];
    logic [8:0] monItem;

    spi_arb #(.XFER_CE(16)) dut (
        .clock(clock), .reset(reset), .cen(cen),
        .a_tx(a_tx), .a_rx(a_rx), .a_d(a_d), .a_cs(a_cs),
        .a_busy(a_busy), .a_gnt(a_gnt), .a_ovf(a_ovf),
        .b_tx(b_tx), .b_rx(b_rx), .b_d(b_d), .b_cs(b_cs),
        .b_busy(b_busy), .b_gnt(b_gnt), .b_ovf(b_ovf),
        .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_d(spi_d), .spi_cs(spi_cs)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Strobe codes are {rx, tx}; strobes last exactly one clock.
    task automatic applyStimulus(input logic [1:0] aStb, input logic [7:0] aByte,
                                 input logic [1:0] bStb, input logic [7:0] bByte);
        a_tx = aStb[0]; a_rx = aStb[1]; a_d = aByte;
        b_tx = bStb[0]; b_rx = bStb[1]; b_d = bByte;
        tick();
        a_tx = 1'b0; a_rx = 1'b0; b_tx = 1'b0; b_rx = 1'b0;
    endtask

    task automatic waitStrobe(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (spi_cs) csHighSamples++;
        end while (!(spi_tx || spi_rx) && n < 300);
        if (!(spi_tx || spi_rx)) checkOutput({tag, " strobe timeout"}, 0, 1);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (!(spi_cs && !a_gnt && !b_gnt && !a_busy && !b_busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) checkOutput({tag, " idle timeout"}, 0, 1);
    endtask

    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cenCount++;
            cen = ((cenCount % cenPeriod) == 0);
        end
    end

    // Every engine strobe is matched against the granted requester's queue.
    initial begin
        forever begin
            @(negedge clock);
            if (a_ovf) ovfCountA++;
            if (b_ovf) ovfCountB++;
            if (!reset && (spi_tx || spi_rx)) begin
                checkOutput("strobe exclusive", {31'b0, spi_tx & spi_rx}, 0);
                if (a_gnt && aExp.size() > 0) begin
                    monItem = aExp.pop_front();
                    checkOutput("A transfer", {23'b0, spi_rx, spi_d}, {23'b0, monItem});
                end else if (b_gnt && bExp.size() > 0) begin
                    monItem = bExp.pop_front();
                    checkOutput("B transfer", {23'b0, spi_rx, spi_d}, {23'b0, monItem});
                end else begin
                    checkOutput("unexpected strobe", {23'b0, spi_rx, spi_d}, 32'h1FF);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int lowCount;
        logic expTieB;
        reset = 1'b1;
        a_tx = 0; a_rx = 0; a_d = 0; a_cs = 1;
        b_tx = 0; b_rx = 0; b_d = 0; b_cs = 1;
        repeat (3) tick();
        checkOutput("reset spi_cs", spi_cs, 1);
        checkOutput("reset spi_d", spi_d, 8'hFF);
        checkOutput("reset strobes", {spi_tx, spi_rx}, 0);
        checkOutput("reset gnt/busy/ovf", {a_gnt, b_gnt, a_busy, b_busy, a_ovf, b_ovf}, 0);
        #2 reset = 1'b0;
        tick();

        // One-shot A write with a_cs high.
        aExp.push_back({1'b0, 8'h40});
        applyStimulus(2'b01, 8'h40, 2'b00, 8'h00);
        checkOutput("t1 busy after strobe", a_busy, 1);
        checkOutput("t1 no strobe yet", spi_tx, 0);
        tick();
        checkOutput("t1 spi_tx", spi_tx, 1);
        checkOutput("t1 spi_d", spi_d, 8'h40);
        checkOutput("t1 a_gnt", a_gnt, 1);
        lowCount = 0;
        while (spi_cs == 1'b0 && lowCount < 100) begin
            lowCount++;
            tick();
        end
        checkOutput("t1 cs low clocks", lowCount, 17);
        checkOutput("t1 released", {a_busy, a_gnt}, 0);

        // A locks the bus with three back-to-back writes while B waits.
        a_cs = 1'b0;
        tick();
        aExp.push_back({1'b0, 8'h11});
        applyStimulus(2'b01, 8'h11, 2'b00, 8'h00);
        tick();
        checkOutput("t2 first spi_tx", spi_tx, 1);
        bExp.push_back({1'b0, 8'hB1});
        applyStimulus(2'b00, 8'h00, 2'b01, 8'hB1);
        aExp.push_back({1'b0, 8'h12});
        applyStimulus(2'b01, 8'h12, 2'b00, 8'h00);
        checkOutput("t2 b_busy held", b_busy, 1);
        csHighSamples = 0;
        waitStrobe("t2 second", n);
        checkOutput("t2 second gap", n, 15);
        aExp.push_back({1'b0, 8'h13});
        applyStimulus(2'b01, 8'h13, 2'b00, 8'h00);
        waitStrobe("t2 third", n);
        checkOutput("t2 third gap", n, 16);
        checkOutput("t2 no idle between", csHighSamples, 0);
        n = 0;
        while (a_busy && n < 100) begin
            tick();
            n++;
        end
        checkOutput("t2 lock held", {spi_cs, a_gnt, b_gnt, b_busy}, 4'b0101);
        a_cs = 1'b1;
        tick();
        checkOutput("t2 release", {spi_cs, a_gnt, spi_tx}, 3'b100);
        tick();
        checkOutput("t2 B issued", {b_gnt, spi_tx}, 2'b11);
        waitIdle("t2");

        // Simultaneous requests in IDLE.
        aExp.push_back({1'b0, 8'h31});
        bExp.push_back({1'b0, 8'h32});
        applyStimulus(2'b01, 8'h31, 2'b01, 8'h32);
        tick();
        checkOutput("t3 tie1 A wins", {a_gnt, b_gnt}, 2'b10);
        waitStrobe("t3 B", n);
        checkOutput("t3 B after A", n, 18);
        checkOutput("t3 B granted", b_gnt, 1);
        waitIdle("t3a");
        aExp.push_back({1'b0, 8'h33});
        applyStimulus(2'b01, 8'h33, 2'b00, 8'h00);
        waitIdle("t3b");
        aExp.push_back({1'b0, 8'h34});
        bExp.push_back({1'b0, 8'h35});
        applyStimulus(2'b01, 8'h34, 2'b01, 8'h35);
        tick();
`ifdef SPI_ARB_RR_EN
        expTieB = 1'b1;
`else
        expTieB = 1'b0;
`endif
        checkOutput("t3 tie2 winner is B", b_gnt, {31'b0, expTieB});
        waitIdle("t3c");

        // Two strobes during own transfer: first queued, second dropped; tx+rx counts as rx.
        aExp.push_back({1'b0, 8'h41});
        applyStimulus(2'b01, 8'h41, 2'b00, 8'h00);
        tick();
        aExp.push_back({1'b1, 8'h42});
        applyStimulus(2'b11, 8'h42, 2'b00, 8'h00);
        applyStimulus(2'b01, 8'h43, 2'b00, 8'h00);
        checkOutput("t4 ovf pulse", a_ovf, 1);
        tick();
        checkOutput("t4 ovf one clock", a_ovf, 0);
        checkOutput("t4 busy", a_busy, 1);
        waitIdle("t4");
        checkOutput("t4 A ovf count", ovfCountA, 1);
        checkOutput("t4 B ovf count", ovfCountB, 0);

        // Reset part-way through a transfer.
        aExp.push_back({1'b0, 8'h51});
        applyStimulus(2'b01, 8'h51, 2'b00, 8'h00);
        tick();
        repeat (8) tick();
        checkOutput("t5 mid transfer", {spi_cs, a_gnt}, 2'b01);
        #2 reset = 1'b1;
        #1;
        checkOutput("t5 reset cs/gnt/busy", {spi_cs, a_gnt, a_busy}, 3'b100);
        checkOutput("t5 reset spi_d", spi_d, 8'hFF);
        tick();
        #2 reset = 1'b0;
        tick();
        aExp.push_back({1'b0, 8'h52});
        applyStimulus(2'b01, 8'h52, 2'b00, 8'h00);
        tick();
        checkOutput("t5 served after reset", {spi_tx, a_gnt, spi_d}, {2'b11, 8'h52});
        waitIdle("t5");

        // B read while B holds the lock, with a slow cen.
        cenPeriod = 4;
        b_cs = 1'b0;
        tick();
        tick();
        checkOutput("t6 B lock", {b_gnt, spi_cs}, 2'b10);
        bExp.push_back({1'b1, 8'h61});
        applyStimulus(2'b00, 8'h00, 2'b10, 8'h61);
        tick();
        checkOutput("t6 spi_rx", {spi_rx, spi_tx}, 2'b10);
        n = 0;
        while (b_busy && n < 200) begin
            n++;
            tick();
        end
        checkOutput("t6 window in 61..66", (n >= 61 && n <= 66), 1);
        checkOutput("t6 back to lock", {b_gnt, spi_cs}, 2'b10);
        b_cs = 1'b1;
        tick();
        checkOutput("t6 released", spi_cs, 1);
        cenPeriod = 1;
        repeat (3) tick();

        checkOutput("A scoreboard drained", aExp.size(), 0);
        checkOutput("B scoreboard drained", bExp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
